conv1d_seq: RTL and testbench
=============================

Name: conv1d_seq

Overview:
- Sequencer that drives the 3-tap signed MAC stage for a 1-D, 3-tap correlation over a feature vector held in SRAM.
- Per job it:
  - clears the MAC;
  - shifts 3 weights in from weight memory;
  - streams N features from feature memory;
  - writes each of the N-2 valid 34-bit MAC results to result memory.
- Sits between the job/host control logic and the MAC. Owns all MAC control strobes.

Parameters:
- DATA_BIT, 16, MAC operand width; result width is 2*DATA_BIT+2.
- ADDR_W, 10, width of all memory addresses.
- LEN_W, 10, width of the feature-length field.
- RELU_EN, 0, 1 = negative results are written as 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  job request, sampled in IDLE only
- len  in  LEN_W  feature count N, latched at start
- w_base  in  ADDR_W  weight base address, latched at start
- if_base  in  ADDR_W  feature base address, latched at start
- res_base  in  ADDR_W  result base address, latched at start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle end-of-job pulse
- err  out  1  valid with done; 1 = len<3
- w_rd  out  1  weight memory read enable
- w_addr  out  ADDR_W  weight read address
- w_rdata  in  DATA_BIT  weight read data, valid the cycle after w_rd
- if_rd  out  1  feature memory read enable
- if_addr  out  ADDR_W  feature read address
- if_rdata  in  DATA_BIT  feature read data, valid the cycle after if_rd
- mac_clear  out  1  MAC clear
- mac_w_w  out  1  MAC weight shift
- mac_w_in  out  DATA_BIT  MAC weight data
- mac_if_w  out  1  MAC feature shift
- mac_if_in  out  DATA_BIT  MAC feature data
- mac_out  in  2*DATA_BIT+2  MAC result; combinational from MAC registers
- res_we  out  1  result write enable
- res_addr  out  ADDR_W  result write address
- res_data  out  2*DATA_BIT+2  result write data

Behaviour:
- Reset: rst is synchronous, active-high; clock clk.
  - On reset, every output is 0 and the state is IDLE.
  - Reset mid-job aborts immediately: no further reads, writes or done.
- States: IDLE -> CLR -> LDW -> LDF -> DRAIN -> DONE -> IDLE.
- Timing is relative to cycle 0, the IDLE cycle in which start=1:
  - Cycle 0: len and the three bases are latched. If len<3, next state is DONE with err=1: done at cycle 1, no memory or MAC activity.
  - Cycle 1 (CLR): mac_clear=1.
  - Cycles 2-4 (LDW): w_rd=1, w_addr = w_base+0..2.
  - Cycles 3-5: mac_w_w=1, mac_w_in = w_rdata. MAC tap2 therefore holds mem[w_base], tap0 holds mem[w_base+2].
  - Cycles 5..N+4 (LDF): if_rd=1, if_addr = if_base+0..N-1.
  - Cycles 6..N+5: mac_if_w=1, mac_if_in = if_rdata.
  - mac_out is valid in cycles 9..N+6. Each valid value is registered.
  - Cycles 10..N+7: res_we=1, res_addr = res_base+0..N-3, res_data = registered mac_out.
  - DRAIN covers the cycles after the last read until the last write.
  - Cycle N+8 (DONE): done=1, err=0. Next cycle is IDLE.
- Result k = f[k]*w[0] + f[k+1]*w[1] + f[k+2]*w[2], where w[i] = mem[w_base+i] and f[j] = mem[if_base+j].
- res_data is mac_out passed bit-exact; no truncation or saturation.
- RELU_EN=1: a result with MSB=1 is written as 0; write timing is unchanged.
- Strobe outputs (mac_*, *_rd, res_we, done) are 0 outside their listed cycles. Data and address outputs hold their last value when their strobe is low.
- start during busy is ignored and not queued. start in the DONE cycle is ignored.
- mac_w_w and mac_if_w are both high in cycle 6 only if N... no: they never overlap. mac_w_w ends at cycle 5 and mac_if_w begins at cycle 6.
- Addresses wrap modulo 2^ADDR_W.
- Latched len is not affected by later changes to the len port.
- Maximum len is 2^LEN_W-1.

Test Plan:
1. Basic job: w mem = [1,2,3], f mem = [1,2,3,4,5], N=5, bases=0, start at cycle 0 -> res_we at cycles 10,11,12 with data 14, 20, 26 and res_addr 0,1,2; done at cycle 13; busy high cycles 1-13.
2. Minimum length: N=3, f = [1,2,3], same weights -> single write of 14 at cycle 10; done at cycle 11.
3. Signed result: w = [-1,0,0], f = [5,0,0], N=3 -> res_data = 34'h3_FFFF_FFFB. With RELU_EN=1 -> res_data = 0.
4. Short length: N=2 -> done and err at cycle 1; w_rd, if_rd, mac_* and res_we never asserted.
5. Reset and busy handling:
   - rst at cycle 8 of a 5-feature job -> all outputs 0 from cycle 9; no done.
   - A new start after rst runs a clean job; the bench checks that mac_clear precedes the weight load.
   - start pulsed at cycle 4 of a running job -> ignored; exactly N-2 writes and one done.
6. Back-to-back and wrap: w_base=1022, if_base=1020, res_base=1023, N=4 -> w_addr 1022,1023,0; if_addr 1020..1023; res_addr 1023 then 0. A second start the cycle after done is accepted.

Source files
------------

// File: rtl/conv1d_seq.sv
// conv1d_seq: job sequencer for a 3-tap signed MAC stage.
// It runs a 1-D, 3-tap correlation over a feature vector held in SRAM.
//
// For each job it:
//   - clears the MAC,
//   - shifts in 3 weights from weight memory,
//   - streams N features from feature memory,
//   - writes the N-2 valid MAC results to result memory.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               job request (only looked at in IDLE)
//   len, *_base         job length and base addresses, latched at start
//   busy, done, err     job status; err qualifies done (1 = len < 3)
//   w_rd/w_addr/w_rdata     weight memory read port (1-cycle read latency)
//   if_rd/if_addr/if_rdata  feature memory read port (1-cycle read latency)
//   mac_*               MAC control strobes and operand data
//   mac_out             MAC result (combinational from the MAC registers)
//   res_we/res_addr/res_data  result memory write port
//
// State table:
//   IDLE  | waiting for start
//   CLR   | MAC clear strobe
//   LDW   | three weight reads
//   LDF   | N feature reads
//   DRAIN | last features shift in and remaining results are written
//   DONE  | done pulse; err reports a rejected (too short) job

module conv1d_seq #(
    parameter int DATA_BIT = 16,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 10,
    parameter int RELU_EN  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [ADDR_W-1:0]       w_base,
    input  logic [ADDR_W-1:0]       if_base,
    input  logic [ADDR_W-1:0]       res_base,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    w_rd,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [DATA_BIT-1:0]     w_rdata,
    output logic                    if_rd,
    output logic [ADDR_W-1:0]       if_addr,
    input  logic [DATA_BIT-1:0]     if_rdata,
    output logic                    mac_clear,
    output logic                    mac_w_w,
    output logic [DATA_BIT-1:0]     mac_w_in,
    output logic                    mac_if_w,
    output logic [DATA_BIT-1:0]     mac_if_in,
    input  logic [2*DATA_BIT+1:0]   mac_out,
    output logic                    res_we,
    output logic [ADDR_W-1:0]       res_addr,
    output logic [2*DATA_BIT+1:0]   res_data
);

    localparam int RES_W = 2*DATA_BIT + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LDW   = 3'd2,
        LDF   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   w_base_q;
    logic [ADDR_W-1:0]   if_base_q;
    logic [ADDR_W-1:0]   res_ptr;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    shift_cnt;
    logic                shift_d;
    logic [DATA_BIT-1:0] w_hold;
    logic [DATA_BIT-1:0] if_hold;
    logic                mac_valid;
    logic [RES_W-1:0]    res_next;

    assign busy = (state != IDLE);

    // Read data arrives one cycle after the read strobe and goes straight to
    // the MAC in that same cycle. The hold registers keep the operand buses
    // stable once the shift strobe drops.
    assign mac_w_in  = mac_w_w  ? w_rdata  : w_hold;
    assign mac_if_in = mac_if_w ? if_rdata : if_hold;

    // The MAC output is a real result once three features have been shifted
    // since the clear, and only in the cycle right after each shift.
    assign mac_valid = shift_d && (shift_cnt >= LEN_W'(3));
    assign res_next  = ((RELU_EN != 0) && mac_out[RES_W-1]) ? '0 : mac_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            w_base_q  <= '0;
            if_base_q <= '0;
            res_ptr   <= '0;
            idx       <= '0;
            shift_cnt <= '0;
            shift_d   <= 1'b0;
            w_hold    <= '0;
            if_hold   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            w_rd      <= 1'b0;
            w_addr    <= '0;
            if_rd     <= 1'b0;
            if_addr   <= '0;
            mac_clear <= 1'b0;
            mac_w_w   <= 1'b0;
            mac_if_w  <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
        end else begin
            // MAC shift strobes trail the matching read strobes by one cycle.
            mac_w_w  <= w_rd;
            mac_if_w <= if_rd;
            shift_d  <= mac_if_w;
            if (mac_w_w)
                w_hold <= w_rdata;
            if (mac_if_w)
                if_hold <= if_rdata;

            if (mac_clear)
                shift_cnt <= '0;
            else if (mac_if_w && (shift_cnt != '1))
                shift_cnt <= shift_cnt + LEN_W'(1);

            res_we <= mac_valid;
            if (mac_valid) begin
                res_data <= res_next;
                res_addr <= res_ptr;
                res_ptr  <= res_ptr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        w_base_q  <= w_base;
                        if_base_q <= if_base;
                        res_ptr   <= res_base;
                        if (len < LEN_W'(3)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= CLR;
                            mac_clear <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    mac_clear <= 1'b0;
                    w_rd      <= 1'b1;
                    w_addr    <= w_base_q;
                    idx       <= LEN_W'(1);
                    state     <= LDW;
                end
                LDW: begin
                    if (idx == LEN_W'(3)) begin
                        w_rd    <= 1'b0;
                        if_rd   <= 1'b1;
                        if_addr <= if_base_q;
                        idx     <= LEN_W'(1);
                        state   <= LDF;
                    end else begin
                        w_addr <= w_addr + ADDR_W'(1);
                        idx    <= idx + LEN_W'(1);
                    end
                end
                LDF: begin
                    if (idx == len_q) begin
                        if_rd <= 1'b0;
                        idx   <= LEN_W'(1);
                        state <= DRAIN;
                    end else begin
                        if_addr <= if_addr + ADDR_W'(1);
                        idx     <= idx + LEN_W'(1);
                    end
                end
                // The last feature read needs three more cycles before its
                // result has been written.
                DRAIN: begin
                    if (idx == LEN_W'(3)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_seq.sv
// tb_conv1d_seq: self-checking bench for conv1d_seq.
//
// Two instances share one pair of memories: instance 0 has RELU_EN=0 and
// instance 1 has RELU_EN=1. Each instance has its own memory read ports and
// its own behavioural MAC.
//
// Every cycle of a job is compared against the strobe schedule, counted from
// the start cycle. Result data is compared against a direct correlation over
// the memory arrays.

module tb_conv1d_seq;

    localparam int DB = 16;
    localparam int AW = 10;
    localparam int LW = 10;
    localparam int RW = 2*DB + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [AW-1:0] w_base, if_base, res_base;

    logic          busy [2];
    logic          done [2];
    logic          err [2];
    logic          w_rd [2];
    logic          if_rd [2];
    logic          mac_clear [2];
    logic          mac_w_w [2];
    logic          mac_if_w [2];
    logic          res_we [2];
    logic [AW-1:0] w_addr [2];
    logic [AW-1:0] if_addr [2];
    logic [AW-1:0] res_addr [2];
    logic [DB-1:0] w_rdata [2];
    logic [DB-1:0] if_rdata [2];
    logic [DB-1:0] mac_w_in [2];
    logic [DB-1:0] mac_if_in [2];
    logic [RW-1:0] mac_out [2];
    logic [RW-1:0] res_data [2];

    logic signed [DB-1:0] wmem [1024];
    logic signed [DB-1:0] fmem [1024];

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic signed [DB-1:0] tw0, tw1, tw2, tf0, tf1, tf2;

        conv1d_seq #(
            .DATA_BIT(DB), .ADDR_W(AW), .LEN_W(LW), .RELU_EN(g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .len       (len),
            .w_base    (w_base),
            .if_base   (if_base),
            .res_base  (res_base),
            .busy      (busy[g]),
            .done      (done[g]),
            .err       (err[g]),
            .w_rd      (w_rd[g]),
            .w_addr    (w_addr[g]),
            .w_rdata   (w_rdata[g]),
            .if_rd     (if_rd[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .mac_clear (mac_clear[g]),
            .mac_w_w   (mac_w_w[g]),
            .mac_w_in  (mac_w_in[g]),
            .mac_if_w  (mac_if_w[g]),
            .mac_if_in (mac_if_in[g]),
            .mac_out   (mac_out[g]),
            .res_we    (res_we[g]),
            .res_addr  (res_addr[g]),
            .res_data  (res_data[g])
        );

        // Synchronous-read SRAMs and a shift-in-at-tap0 MAC.
        always @(posedge clk) begin
            if (w_rd[g])
                w_rdata[g] <= wmem[w_addr[g]];
            if (if_rd[g])
                if_rdata[g] <= fmem[if_addr[g]];
            if (mac_clear[g]) begin
                tw0 <= '0; tw1 <= '0; tw2 <= '0;
                tf0 <= '0; tf1 <= '0; tf2 <= '0;
            end else begin
                if (mac_w_w[g]) begin
                    tw2 <= tw1; tw1 <= tw0; tw0 <= mac_w_in[g];
                end
                if (mac_if_w[g]) begin
                    tf2 <= tf1; tf1 <= tf0; tf0 <= mac_if_in[g];
                end
            end
        end

        always_comb begin
            longint s;
            s = longint'(tw2) * longint'(tf2) + longint'(tw1) * longint'(tf1)
              + longint'(tw0) * longint'(tf0);
            mac_out[g] = s[RW-1:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] strobes(input int i);
        return {busy[i], mac_clear[i], w_rd[i], mac_w_w[i], if_rd[i],
                mac_if_w[i], res_we[i], done[i], err[i]};
    endfunction

    // Result k = f[k]*w[0] + f[k+1]*w[1] + f[k+2]*w[2], with addresses wrapping.
    function automatic logic [RW-1:0] ref_res(input int k, input int relu,
                                              input logic [AW-1:0] wb,
                                              input logic [AW-1:0] fb);
        longint s;
        logic [AW-1:0] wa, fa;
        s = 0;
        for (int t = 0; t < 3; t++) begin
            wa = wb + AW'(t);
            fa = fb + AW'(k + t);
            s += longint'(wmem[wa]) * longint'(fmem[fa]);
        end
        if (relu != 0 && s < 0)
            s = 0;
        return s[RW-1:0];
    endfunction

    task automatic zero_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s dut%0d strobes", tag, i), 64'(strobes(i)), 64'd0);
            chk($sformatf("%s dut%0d addr/win", tag, i),
                64'({w_addr[i], if_addr[i], res_addr[i], mac_w_in[i]}), 64'd0);
            chk($sformatf("%s dut%0d data/ifin", tag, i),
                64'({res_data[i], mac_if_in[i]}), 64'd0);
        end
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                chk($sformatf("idle dut%0d strobes", i), 64'(strobes(i)), 64'd0);
            rst   = 1'b0;
            start = 1'b0;
        end
    endtask

    // Cycle 0 is the IDLE cycle in which start is high. rst_at >= 0 raises
    // rst in that cycle; spulse >= 0 repeats start in that cycle.
    task automatic run_job(input int n, input logic [AW-1:0] wb,
                           input logic [AW-1:0] fb, input logic [AW-1:0] rb,
                           input int rst_at, input int spulse);
        int            last, fin;
        bit            short_j, live;
        logic [8:0]    es;
        logic [AW-1:0] ea;
        short_j = (n < 3);
        fin     = short_j ? 1 : n + 8;
        last    = (rst_at >= 0) ? n + 9 : fin;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            live  = (rst_at < 0) || (c <= rst_at);
            es[8] = live && c >= 1 && c <= fin;
            es[7] = live && !short_j && c == 1;
            es[6] = live && !short_j && c >= 2 && c <= 4;
            es[5] = live && !short_j && c >= 3 && c <= 5;
            es[4] = live && !short_j && c >= 5 && c <= n + 4;
            es[3] = live && !short_j && c >= 6 && c <= n + 5;
            es[2] = live && !short_j && c >= 10 && c <= n + 7;
            es[1] = live && c == fin;
            es[0] = live && short_j && c == 1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("n%0d c%0d dut%0d strobes", n, c, i), 64'(strobes(i)), 64'(es));
                if (es[6]) begin
                    ea = wb + AW'(c - 2);
                    chk($sformatf("c%0d dut%0d w_addr", c, i), 64'(w_addr[i]), 64'(ea));
                end
                if (es[5]) begin
                    ea = wb + AW'(c - 3);
                    chk($sformatf("c%0d dut%0d mac_w_in", c, i), 64'(mac_w_in[i]),
                        64'($unsigned(wmem[ea])));
                end
                if (es[4]) begin
                    ea = fb + AW'(c - 5);
                    chk($sformatf("c%0d dut%0d if_addr", c, i), 64'(if_addr[i]), 64'(ea));
                end
                if (es[3]) begin
                    ea = fb + AW'(c - 6);
                    chk($sformatf("c%0d dut%0d mac_if_in", c, i), 64'(mac_if_in[i]),
                        64'($unsigned(fmem[ea])));
                end
                if (es[2]) begin
                    ea = rb + AW'(c - 10);
                    chk($sformatf("c%0d dut%0d res_addr", c, i), 64'(res_addr[i]), 64'(ea));
                    chk($sformatf("c%0d dut%0d res_data", c, i), 64'(res_data[i]),
                        64'(ref_res(c - 10, i, wb, fb)));
                end
            end
            if (rst_at >= 0 && c == rst_at + 1)
                zero_outputs($sformatf("abort c%0d", c));
            rst   = (c == rst_at);
            start = (c == 0) || (c == spulse);
            if (c == 0) begin
                len = LW'(n); w_base = wb; if_base = fb; res_base = rb;
            end else begin
                len      = LW'($urandom);
                w_base   = AW'($urandom);
                if_base  = AW'($urandom);
                res_base = AW'($urandom);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        w_base = '0; if_base = '0; res_base = '0;
        for (int a = 0; a < 1024; a++) begin
            wmem[a] = DB'($urandom);
            fmem[a] = DB'($urandom);
        end
        repeat (3) @(negedge clk);
        zero_outputs("reset");
        idle(2);

        // basic job and minimum length
        wmem[0] = 16'sd1; wmem[1] = 16'sd2; wmem[2] = 16'sd3;
        for (int a = 0; a < 5; a++) fmem[a] = DB'(a + 1);
        run_job(5, 10'd0, 10'd0, 10'd0, -1, -1);
        idle(1);
        run_job(3, 10'd0, 10'd0, 10'd0, -1, -1);
        idle(1);

        // negative result, raw and clamped
        wmem[100] = -16'sd1; wmem[101] = 16'sd0; wmem[102] = 16'sd0;
        fmem[200] = 16'sd5;  fmem[201] = 16'sd0; fmem[202] = 16'sd0;
        run_job(3, 10'd100, 10'd200, 10'd300, -1, -1);
        idle(1);

        // rejected short jobs
        run_job(2, 10'd5, 10'd6, 10'd7, -1, -1);
        run_job(0, 10'd5, 10'd6, 10'd7, -1, -1);
        run_job(1, 10'd5, 10'd6, 10'd7, -1, -1);
        idle(1);

        // abort, clean restart, ignored start while busy
        run_job(5, 10'd0, 10'd0, 10'd0, 8, -1);
        run_job(5, 10'd0, 10'd0, 10'd50, -1, -1);
        run_job(5, 10'd3, 10'd9, 10'd60, -1, 4);
        idle(1);

        // address wrap, then back-to-back start the cycle after done
        run_job(4, 10'd1022, 10'd1020, 10'd1023, -1, -1);
        run_job(6, 10'd1021, 10'd1019, 10'd1020, -1, -1);

        for (int j = 0; j < 12; j++) begin
            int n, ra, sp;
            n  = $urandom_range(0, 24);
            ra = -1;
            sp = -1;
            for (int a = 0; a < 1024; a++) begin
                wmem[a] = DB'($urandom);
                fmem[a] = DB'($urandom);
            end
            if (n >= 3) begin
                case ($urandom_range(0, 3))
                    0:       sp = $urandom_range(1, n + 8);
                    1:       ra = $urandom_range(1, n + 8);
                    default: ;
                endcase
            end
            run_job(n, AW'($urandom), AW'($urandom), AW'($urandom), ra, sp);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
